// File: rtl/fm_cmn_bram_fifo_if.sv
// Write/read handshake bundle for fm_cmn_bram_fifo.
// slave = FIFO side, master = user side.
interface fm_cmn_bram_fifo_if #(
  parameter int P_WIDTH = 32,
  parameter int P_RANGE = 4
);
  logic               i_clear;
  logic               i_wstrobe;
  logic [P_WIDTH-1:0] i_dt;
  logic               o_full;
  logic               o_afull;
  logic               o_valid;
  logic [P_WIDTH-1:0] o_dt;
  logic               i_rstrobe;
  logic [P_RANGE:0]   o_dnum;
  logic               o_err_ovf;
  logic               o_err_udf;

  modport slave (
    input  i_clear, i_wstrobe, i_dt, i_rstrobe,
    output o_full, o_afull, o_valid, o_dt, o_dnum, o_err_ovf, o_err_udf
  );

  modport master (
    output i_clear, i_wstrobe, i_dt, i_rstrobe,
    input  o_full, o_afull, o_valid, o_dt, o_dnum, o_err_ovf, o_err_udf
  );
endinterface

// File: rtl/fm_cmn_bram_fifo.sv
// Block-RAM FIFO with first-word-fall-through head: the RAM read register
// drives o_dt directly, kept filled by a small EMPTY/FETCH/HEAD prefetch FSM.
module fm_cmn_bram_fifo #(
  parameter int P_WIDTH = 32,
  parameter int P_RANGE = 4,
  parameter int P_AFULL = (1 << P_RANGE) - 2
) (
  input  logic                   clk_core,
  input  logic                   rst_x,
  fm_cmn_bram_fifo_if.slave      s_if
);
  localparam int P_DEPTH = 1 << P_RANGE;
  localparam logic [P_RANGE:0] L_DEPTH = P_DEPTH[P_RANGE:0];
  localparam logic [P_RANGE:0] L_AFULL = P_AFULL[P_RANGE:0];

  typedef enum logic [1:0] {S_EMPTY, S_FETCH, S_HEAD} state_t;

  logic [P_WIDTH-1:0] r_mem [P_DEPTH];
  logic [P_WIDTH-1:0] r_rdata;
  logic [P_RANGE-1:0] r_wptr, r_rptr;
  logic [P_RANGE:0]   r_dnum, r_ram_cnt;
  logic               r_full, r_afull, r_valid, r_ovf, r_udf;
  state_t             r_state;

  logic               w_wr_acc, w_rd_acc, w_rd_iss, w_more;
  logic [P_RANGE:0]   w_dnum_nxt, w_ram_cnt_nxt;

  // r_ram_cnt: entries committed to RAM on earlier edges and not yet fetched
  assign w_more   = (r_ram_cnt != '0);
  assign w_wr_acc = s_if.i_wstrobe & ~r_full;
  assign w_rd_acc = s_if.i_rstrobe & r_valid;
  assign w_rd_iss = (r_state == S_FETCH) | (w_rd_acc & w_more);

  always_comb begin
    w_dnum_nxt    = r_dnum;
    w_ram_cnt_nxt = r_ram_cnt;
    if (w_wr_acc & ~w_rd_acc)      w_dnum_nxt = r_dnum + 1'b1;
    else if (w_rd_acc & ~w_wr_acc) w_dnum_nxt = r_dnum - 1'b1;
    if (w_wr_acc & ~w_rd_iss)      w_ram_cnt_nxt = r_ram_cnt + 1'b1;
    else if (w_rd_iss & ~w_wr_acc) w_ram_cnt_nxt = r_ram_cnt - 1'b1;
  end

  // RAM array kept reset-free so it maps onto block RAM
  always_ff @(posedge clk_core) begin
    if (w_wr_acc & ~s_if.i_clear) r_mem[r_wptr] <= s_if.i_dt;
  end

  always_ff @(posedge clk_core or negedge rst_x) begin
    if (!rst_x) begin
      r_state   <= S_EMPTY;
      r_rdata   <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_dnum    <= '0;
      r_ram_cnt <= '0;
      r_full    <= 1'b0;
      r_afull   <= 1'b0;
      r_valid   <= 1'b0;
      r_ovf     <= 1'b0;
      r_udf     <= 1'b0;
    end else if (s_if.i_clear) begin
      r_state   <= S_EMPTY;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_dnum    <= '0;
      r_ram_cnt <= '0;
      r_full    <= 1'b0;
      r_afull   <= 1'b0;
      r_valid   <= 1'b0;
      r_ovf     <= 1'b0;
      r_udf     <= 1'b0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
      if (w_rd_iss) begin
        r_rdata <= r_mem[r_rptr];
        r_rptr  <= r_rptr + 1'b1;
      end
      r_dnum    <= w_dnum_nxt;
      r_ram_cnt <= w_ram_cnt_nxt;
      r_full    <= (w_dnum_nxt == L_DEPTH);
      r_afull   <= (w_dnum_nxt >= L_AFULL);
      if (s_if.i_wstrobe & r_full)   r_ovf <= 1'b1;
      if (s_if.i_rstrobe & ~r_valid) r_udf <= 1'b1;
      case (r_state)
        S_EMPTY: if (w_more) r_state <= S_FETCH;
        S_FETCH: begin
          r_state <= S_HEAD;
          r_valid <= 1'b1;
        end
        S_HEAD: if (w_rd_acc && !w_more) begin
          r_state <= S_EMPTY;
          r_valid <= 1'b0;
        end
        default: begin
          r_state <= S_EMPTY;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign s_if.o_dt      = r_rdata;
  assign s_if.o_valid   = r_valid;
  assign s_if.o_dnum    = r_dnum;
  assign s_if.o_full    = r_full;
  assign s_if.o_afull   = r_afull;
  assign s_if.o_err_ovf = r_ovf;
  assign s_if.o_err_udf = r_udf;
endmodule

// File: tb/tb_fm_cmn_bram_fifo.sv
// Directed bench for fm_cmn_bram_fifo: vector table plus hand sequences
// for fill/overflow/drain, streaming across wrap, and async reset.
module tb_fm_cmn_bram_fifo;
  logic clk_core = 1'b0;
  logic rst_x;
  always #5 clk_core = ~clk_core;

  fm_cmn_bram_fifo_if #(.P_WIDTH(32), .P_RANGE(4)) bus ();
  fm_cmn_bram_fifo #(.P_WIDTH(32), .P_RANGE(4), .P_AFULL(14)) dut (
    .clk_core (clk_core),
    .rst_x    (rst_x),
    .s_if     (bus)
  );

  typedef struct {
    logic        clr, ws, rs;
    logic [31:0] dt;
    logic        ev;
    logic [31:0] edt;
    logic [4:0]  ednum;
    logic        eudf;
  } vec_t;

  vec_t vq[$];
  int   nvec = 0;
  int   nerr = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  task automatic add(input logic clr, ws, rs, input logic [31:0] dt,
                     input logic ev, input logic [31:0] edt,
                     input logic [4:0] ednum, input logic eudf);
    vec_t v;
    v.clr = clr; v.ws = ws; v.rs = rs; v.dt = dt;
    v.ev = ev; v.edt = edt; v.ednum = ednum; v.eudf = eudf;
    vq.push_back(v);
  endtask

  task automatic drive(input logic clr, ws, rs, input logic [31:0] dt);
    bus.i_clear = clr; bus.i_wstrobe = ws; bus.i_rstrobe = rs; bus.i_dt = dt;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"}, bus.o_valid, 0);
    chk({tag, ".dnum"}, bus.o_dnum, 0);
    chk({tag, ".full"}, bus.o_full, 0);
    chk({tag, ".afull"}, bus.o_afull, 0);
    chk({tag, ".ovf"}, bus.o_err_ovf, 0);
    chk({tag, ".udf"}, bus.o_err_udf, 0);
    chk({tag, ".dt"}, bus.o_dt, 0);
  endtask

  initial begin
    rst_x = 1'b0;
    drive(0, 0, 0, 0);
    #12;
    chk_zero("reset");
    rst_x = 1'b1;

    //  clr ws rs  dt            ev  edt           dnum udf
    add(0, 1, 0, 32'hA5A5A5A5, 0, 0,            1, 0);  // edge 0
    add(0, 0, 0, 0,            0, 0,            1, 0);
    add(0, 0, 0, 0,            1, 32'hA5A5A5A5, 1, 0);  // valid after edge 2
    add(0, 0, 1, 0,            0, 0,            0, 0);
    add(0, 0, 1, 0,            0, 0,            0, 1);  // underflow
    add(0, 0, 0, 0,            0, 0,            0, 1);
    add(1, 0, 0, 0,            0, 0,            0, 0);  // clear drops udf
    add(0, 1, 0, 1,            0, 0,            1, 0);
    add(0, 1, 0, 2,            0, 0,            2, 0);
    add(0, 1, 0, 3,            1, 1,            3, 0);
    add(0, 1, 1, 4,            1, 2,            3, 0);
    add(0, 0, 1, 0,            1, 3,            2, 0);
    add(0, 0, 1, 0,            1, 4,            1, 0);
    add(0, 0, 1, 0,            0, 0,            0, 0);
    add(0, 1, 0, 10,           0, 0,            1, 0);
    add(0, 1, 0, 11,           0, 0,            2, 0);
    add(0, 1, 0, 12,           1, 10,           3, 0);
    add(0, 1, 0, 13,           1, 10,           4, 0);
    add(0, 1, 0, 14,           1, 10,           5, 0);
    add(1, 1, 1, 15,           0, 0,            0, 0);  // clear wins over w+r
    add(0, 0, 0, 0,            0, 0,            0, 0);
    add(0, 1, 0, 32'h55,       0, 0,            1, 0);
    add(0, 0, 0, 0,            0, 0,            1, 0);
    add(0, 0, 0, 0,            1, 32'h55,       1, 0);
    add(0, 0, 1, 0,            0, 0,            0, 0);

    foreach (vq[i]) begin
      drive(vq[i].clr, vq[i].ws, vq[i].rs, vq[i].dt);
      tick();
      chk($sformatf("v%0d.valid", i), bus.o_valid, vq[i].ev);
      if (vq[i].ev) chk($sformatf("v%0d.dt", i), bus.o_dt, vq[i].edt);
      chk($sformatf("v%0d.dnum", i), bus.o_dnum, vq[i].ednum);
      chk($sformatf("v%0d.udf", i), bus.o_err_udf, vq[i].eudf);
      chk($sformatf("v%0d.full", i), bus.o_full, 0);
      chk($sformatf("v%0d.ovf", i), bus.o_err_ovf, 0);
    end

    // fill 16 (pointers start at 1, so this wraps), overflow, drain
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 0, i);
      tick();
      chk($sformatf("fill%0d.dnum", i), bus.o_dnum, i + 1);
      chk($sformatf("fill%0d.full", i), bus.o_full, (i == 15));
      chk($sformatf("fill%0d.afull", i), bus.o_afull, (i + 1 >= 14));
    end
    drive(0, 1, 0, 32'hDEAD);
    tick();
    chk("ovf.flag", bus.o_err_ovf, 1);
    chk("ovf.dnum", bus.o_dnum, 16);
    chk("ovf.full", bus.o_full, 1);
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 1, 0);
      chk($sformatf("drain%0d.valid", i), bus.o_valid, 1);
      chk($sformatf("drain%0d.dt", i), bus.o_dt, i);
      tick();
      chk($sformatf("drain%0d.dnum", i), bus.o_dnum, 15 - i);
      chk($sformatf("drain%0d.full", i), bus.o_full, 0);
      chk($sformatf("drain%0d.afull", i), bus.o_afull, (15 - i >= 14));
    end
    drive(0, 0, 0, 0);
    chk("drain.end_valid", bus.o_valid, 0);

    // streaming: 3 deep, write+read each cycle across pointer wrap
    drive(1, 0, 0, 0);
    tick();
    chk("clr.ovf", bus.o_err_ovf, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 100 + i);
      tick();
    end
    for (int k = 0; k < 40; k++) begin
      drive(0, 1, 1, 103 + k);
      chk($sformatf("strm%0d.valid", k), bus.o_valid, 1);
      chk($sformatf("strm%0d.dt", k), bus.o_dt, 100 + k);
      tick();
      chk($sformatf("strm%0d.dnum", k), bus.o_dnum, 3);
    end
    drive(0, 0, 0, 0);

    // async reset mid-stream at 7 entries
    drive(1, 0, 0, 0);
    tick();
    for (int i = 0; i < 7; i++) begin
      drive(0, 1, 0, 32'h200 + i);
      tick();
    end
    drive(0, 0, 0, 0);
    tick();
    chk("pre_rst.dnum", bus.o_dnum, 7);
    chk("pre_rst.afull", bus.o_afull, 0);
    #3 rst_x = 1'b0;
    #1 chk_zero("async_rst");
    tick();
    rst_x = 1'b1;
    drive(0, 1, 0, 32'h77);
    tick();
    chk("rst_lat0.valid", bus.o_valid, 0);
    chk("rst_lat0.dnum", bus.o_dnum, 1);
    drive(0, 0, 0, 0);
    tick();
    chk("rst_lat1.valid", bus.o_valid, 0);
    tick();
    chk("rst_lat2.valid", bus.o_valid, 1);
    chk("rst_lat2.dt", bus.o_dt, 32'h77);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
